// File: rtl/bp_update_ctrl.sv
// Branch predictor update controller: mispredict detection, serialized table
// writes through a small FIFO, and a clear sweep after reset or on request.
module bp_update_ctrl #(
   parameter int ENTRY_ADDR_LEN = 12,
   parameter int QUEUE_DEPTH    = 4,
   parameter int CNT_W          = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_EX,
   input  logic [6:0]                  opcode_EX,
   input  logic [31:0]                 PC_origin_EX,
   input  logic [31:0]                 PC_target_EX,
   input  logic                        br_EX,
   input  logic                        pred_taken_EX,
   input  logic [31:0]                 pred_target_EX,
   input  logic                        clr_req,
   output logic                        flush_req,
   output logic [31:0]                 PC_redirect,
   output logic                        stall_EX,
   output logic                        pred_block,
   output logic                        tbl_we,
   output logic [ENTRY_ADDR_LEN-1:0]   tbl_waddr,
   output logic [31-ENTRY_ADDR_LEN:0]  tbl_wtag,
   output logic [31:0]                 tbl_wtarget,
   output logic                        tbl_wtaken,
   output logic                        tbl_wvalid,
   output logic [CNT_W-1:0]            br_cnt,
   output logic [CNT_W-1:0]            miss_cnt
);

   localparam int ENTRY_SIZE = 2 ** ENTRY_ADDR_LEN;
   localparam int TAG_W      = 32 - ENTRY_ADDR_LEN;
   localparam int PW         = $clog2(QUEUE_DEPTH);
   localparam logic [6:0]                OP_BRANCH = 7'b1100011;
   localparam logic [ENTRY_ADDR_LEN-1:0] LAST_IDX  = ENTRY_ADDR_LEN'(ENTRY_SIZE - 1);
   localparam logic [ENTRY_ADDR_LEN-1:0] IDX_ONE   = ENTRY_ADDR_LEN'(1);
   localparam logic [PW-1:0]             PTR_ONE   = PW'(1);
   localparam logic [PW:0]               CNTQ_ONE  = (PW + 1)'(1);
   localparam logic [PW:0]               CNTQ_FULL = (PW + 1)'(QUEUE_DEPTH);
   localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                    r_state, w_state_nxt;
   logic [ENTRY_ADDR_LEN-1:0] r_sweep_idx;
   logic [ENTRY_ADDR_LEN-1:0] r_q_idx    [QUEUE_DEPTH];
   logic [TAG_W-1:0]          r_q_tag    [QUEUE_DEPTH];
   logic [31:0]               r_q_target [QUEUE_DEPTH];
   logic                      r_q_taken  [QUEUE_DEPTH];
   logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
   logic [PW:0]               r_count;
   logic [CNT_W-1:0]          r_br_cnt, r_miss_cnt;
   logic                      w_ev, w_push, w_pop, w_clr_run;
   logic [31:0]               w_seq_pc, w_act, w_prd;

   // Stall comes from the registered count only, so a same-cycle pop never frees a slot.
   assign stall_EX    = (r_count == CNTQ_FULL);
   assign w_ev        = valid_EX & (opcode_EX == OP_BRANCH) & ~stall_EX;
   assign w_seq_pc    = PC_origin_EX + 32'd4;
   assign w_act       = br_EX ? PC_target_EX : w_seq_pc;
   assign w_prd       = pred_taken_EX ? pred_target_EX : w_seq_pc;
   assign flush_req   = w_ev & (w_act != w_prd);
   assign PC_redirect = flush_req ? w_act : 32'd0;
   assign w_clr_run   = (r_state == ST_RUN) & clr_req;
   assign w_push      = w_ev & (r_state == ST_RUN) & ~clr_req;
   assign w_pop       = (r_state == ST_RUN) & (r_count != '0);
   assign br_cnt      = r_br_cnt;
   assign miss_cnt    = r_miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_CLEAR;
         r_sweep_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CLEAR)
            r_sweep_idx <= r_sweep_idx + IDX_ONE;
         else if (clr_req)
            r_sweep_idx <= '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      pred_block  = 1'b0;
      tbl_we      = 1'b0;
      tbl_waddr   = '0;
      tbl_wtag    = '0;
      tbl_wtarget = '0;
      tbl_wtaken  = 1'b0;
      tbl_wvalid  = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            pred_block = 1'b1;
            tbl_we     = 1'b1;
            tbl_waddr  = r_sweep_idx;
            if (r_sweep_idx == LAST_IDX)
               w_state_nxt = ST_RUN;
         end
         default: begin
            if (r_count != '0) begin
               tbl_we      = 1'b1;
               tbl_waddr   = r_q_idx[r_rd_ptr];
               tbl_wtag    = r_q_tag[r_rd_ptr];
               tbl_wtarget = r_q_target[r_rd_ptr];
               tbl_wtaken  = r_q_taken[r_rd_ptr];
               tbl_wvalid  = 1'b1;
            end
            if (clr_req)
               w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_clr_run) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNTQ_ONE;
            2'b01:   r_count <= r_count - CNTQ_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_idx[r_wr_ptr]    <= PC_origin_EX[ENTRY_ADDR_LEN-1:0];
         r_q_tag[r_wr_ptr]    <= PC_origin_EX[31:ENTRY_ADDR_LEN];
         r_q_target[r_wr_ptr] <= PC_target_EX;
         r_q_taken[r_wr_ptr]  <= br_EX;
      end
   end

   // Statistics saturate and survive clr_req; only rst zeroes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_ev && (r_br_cnt != '1))
            r_br_cnt <= r_br_cnt + CNT_ONE;
         if (flush_req && (r_miss_cnt != '1))
            r_miss_cnt <= r_miss_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the update controller.
module tb_bp_update_ctrl;

   localparam int EAL  = 3;
   localparam int QD   = 4;
   localparam int CW   = 4;
   localparam int ES   = 8;
   localparam int CMAX = 15;
   localparam logic [6:0] BR_OP = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_EX, br_EX, pred_taken_EX, clr_req;
   logic [6:0]  opcode_EX;
   logic [31:0] PC_origin_EX, PC_target_EX, pred_target_EX;
   logic        flush_req, stall_EX, pred_block, tbl_we, tbl_wtaken, tbl_wvalid;
   logic [31:0] PC_redirect, tbl_wtarget;
   logic [2:0]  tbl_waddr;
   logic [28:0] tbl_wtag;
   logic [3:0]  br_cnt, miss_cnt;

   int n_checks = 0;
   int n_err    = 0;

   // reference model: a pending-update queue of {pc, target, taken}
   bit          m_clr;
   int          m_sweep;
   int          m_br, m_miss;
   logic [64:0] exp_q[$];

   logic        e_ev, e_flush, e_stall, e_pblock;
   logic [31:0] e_redir;
   logic [66:0] e_port;

   always #5 clk = ~clk;

   bp_update_ctrl #(.ENTRY_ADDR_LEN(EAL), .QUEUE_DEPTH(QD), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
      .PC_origin_EX(PC_origin_EX), .PC_target_EX(PC_target_EX), .br_EX(br_EX),
      .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX), .clr_req(clr_req),
      .flush_req(flush_req), .PC_redirect(PC_redirect), .stall_EX(stall_EX),
      .pred_block(pred_block), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wtag(tbl_wtag),
      .tbl_wtarget(tbl_wtarget), .tbl_wtaken(tbl_wtaken), .tbl_wvalid(tbl_wvalid),
      .br_cnt(br_cnt), .miss_cnt(miss_cnt)
   );

   function automatic void model_reset();
      m_clr   = 1'b1;
      m_sweep = 0;
      m_br    = 0;
      m_miss  = 0;
      exp_q.delete();
   endfunction

   function automatic void model_eval();
      logic [31:0] act, prd;
      logic [64:0] h;
      e_stall  = (exp_q.size() == QD);
      e_ev     = valid_EX && (opcode_EX == BR_OP) && !e_stall;
      act      = br_EX ? PC_target_EX : PC_origin_EX + 32'd4;
      prd      = pred_taken_EX ? pred_target_EX : PC_origin_EX + 32'd4;
      e_flush  = e_ev && (act != prd);
      e_redir  = e_flush ? act : 32'd0;
      e_pblock = m_clr;
      e_port   = '0;
      if (m_clr) begin
         e_port = {1'b1, 3'(m_sweep), 29'd0, 32'd0, 1'b0, 1'b0};
      end else if (exp_q.size() > 0) begin
         h      = exp_q[0];
         e_port = {1'b1, h[35:33], h[64:36], h[32:1], h[0], 1'b1};
      end
   endfunction

   function automatic void model_step();
      if (rst) begin
         model_reset();
         return;
      end
      if (e_ev)    m_br   = (m_br < CMAX) ? m_br + 1 : CMAX;
      if (e_flush) m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
      if (m_clr) begin
         m_sweep++;
         if (m_sweep == ES) begin
            m_clr   = 1'b0;
            m_sweep = 0;
         end
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (clr_req) begin
            exp_q.delete();
            m_clr   = 1'b1;
            m_sweep = 0;
         end else if (e_ev) begin
            exp_q.push_back({PC_origin_EX, PC_target_EX, br_EX});
         end
      end
   endfunction

   task automatic set_in(input logic v, input logic [6:0] op, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic b, input logic pt,
                         input logic [31:0] ptg, input logic c);
      valid_EX       = v;
      opcode_EX      = op;
      PC_origin_EX   = pc;
      PC_target_EX   = tgt;
      br_EX          = b;
      pred_taken_EX  = pt;
      pred_target_EX = ptg;
      clr_req        = c;
   endtask

   task automatic set_idle();
      set_in(1'b0, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         set_idle();
         @(negedge clk);
         model_eval();
         adv();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      model_reset();
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({flush_req, stall_EX, pred_block, tbl_we, tbl_wvalid, tbl_wtaken} !== 6'b001100) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 001100",
                  {flush_req, stall_EX, pred_block, tbl_we, tbl_wvalid, tbl_wtaken});
      end
      n_checks++;
      if ({PC_redirect, tbl_wtarget, tbl_wtag, tbl_waddr} !== '0) begin
         n_err++;
         $display("FAIL reset_data: redirect %h target %h tag %h addr %h expected all 0",
                  PC_redirect, tbl_wtarget, tbl_wtag, tbl_waddr);
      end
      n_checks++;
      if ({br_cnt, miss_cnt} !== 8'd0) begin
         n_err++;
         $display("FAIL reset_counters: got %h/%h expected 0/0", br_cnt, miss_cnt);
      end
      adv();
      adv();
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      logic [2:0] a;
      for (int i = 0; i < ES; i++) begin
         a = 3'(i);
         set_idle();
         @(negedge clk);
         model_eval();
         n_checks++;
         if ({tbl_we, tbl_wvalid, pred_block} !== 3'b101 || tbl_waddr !== a) begin
            n_err++;
            $display("FAIL sweep_%0d: we/valid/block %b addr %0d expected 101 addr %0d",
                     i, {tbl_we, tbl_wvalid, pred_block}, tbl_waddr, a);
         end
         adv();
      end
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({pred_block, tbl_we} !== 2'b00) begin
         n_err++;
         $display("FAIL sweep_done: block/we %b expected 00", {pred_block, tbl_we});
      end
      adv();
   endtask

   task automatic test_mispredict();
      set_in(1'b1, BR_OP, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (flush_req !== 1'b1 || PC_redirect !== 32'h80) begin
         n_err++;
         $display("FAIL mispredict_flush: flush %b redirect %h expected 1 00000080", flush_req, PC_redirect);
      end
      adv();
      set_idle();
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid} !==
          {1'b1, 3'd0, 29'h20, 32'h80, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL mispredict_write: we %b addr %h tag %h target %h taken %b valid %b expected 1 0 20 80 1 1",
                  tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid);
      end
      n_checks++;
      if (br_cnt !== 4'd1 || miss_cnt !== 4'd1) begin
         n_err++;
         $display("FAIL mispredict_counts: got %0d/%0d expected 1/1", br_cnt, miss_cnt);
      end
      adv();
   endtask

   task automatic test_not_taken();
      set_in(1'b1, BR_OP, 32'h104, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (flush_req !== 1'b0 || PC_redirect !== 32'h0) begin
         n_err++;
         $display("FAIL correct_nt: flush %b redirect %h expected 0 0", flush_req, PC_redirect);
      end
      adv();
      // predicted taken to 0x10C, actually falls through to 0x108
      set_in(1'b1, BR_OP, 32'h104, 32'h200, 1'b0, 1'b1, 32'h10C, 1'b0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (flush_req !== 1'b1 || PC_redirect !== 32'h108) begin
         n_err++;
         $display("FAIL wrong_taken: flush %b redirect %h expected 1 00000108", flush_req, PC_redirect);
      end
      n_checks++;
      if ({tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid} !==
          {1'b1, 3'd4, 29'h20, 32'h200, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL nt_write: we %b addr %h tag %h target %h taken %b valid %b expected 1 4 20 200 0 1",
                  tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid);
      end
      adv();
      set_idle();
      @(negedge clk);
      model_eval();
      n_checks++;
      if (tbl_we !== 1'b1 || tbl_waddr !== 3'd4 || tbl_wtaken !== 1'b0 || br_cnt !== 4'd3 || miss_cnt !== 4'd2) begin
         n_err++;
         $display("FAIL nt_second: we %b addr %0d taken %b cnt %0d/%0d expected 1 4 0 3/2",
                  tbl_we, tbl_waddr, tbl_wtaken, br_cnt, miss_cnt);
      end
      adv();
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      for (int i = 0; i < 7; i++) begin
         pc = $urandom & 32'hFFFF_FFFC;
         if (i < 6) set_in(1'b1, BR_OP, pc, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
         else       set_idle();
         @(negedge clk);
         model_eval();
         n_checks++;
         if (stall_EX !== e_stall ||
             {tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid} !== e_port) begin
            n_err++;
            $display("FAIL b2b_%0d: stall %b port %h expected stall %b port %h", i, stall_EX,
                     {tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid}, e_stall, e_port);
         end
         adv();
      end
   endtask

   task automatic test_clr_discard();
      set_in(1'b1, BR_OP, 32'h0000_1238, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0);
      @(negedge clk);
      model_eval();
      adv();
      // a branch arriving with clr_req is counted but never queued
      set_in(1'b1, BR_OP, 32'h0000_2224, 32'h90, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (tbl_we !== 1'b1 || tbl_waddr !== 3'd0 || tbl_wtag !== 29'h247 || tbl_wvalid !== 1'b1) begin
         n_err++;
         $display("FAIL clr_head: we %b addr %0d tag %h valid %b expected 1 0 247 1",
                  tbl_we, tbl_waddr, tbl_wtag, tbl_wvalid);
      end
      adv();
      for (int i = 0; i < ES; i++) begin
         set_idle();
         if (i == 3) clr_req = 1'b1;
         @(negedge clk);
         model_eval();
         n_checks++;
         if ({pred_block, tbl_we, tbl_wvalid} !== 3'b110 || tbl_waddr !== 3'(i)) begin
            n_err++;
            $display("FAIL clr_sweep_%0d: block/we/valid %b addr %0d expected 110 addr %0d",
                     i, {pred_block, tbl_we, tbl_wvalid}, tbl_waddr, i);
         end
         adv();
      end
      set_idle();
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({pred_block, tbl_we} !== 2'b00 || br_cnt !== 4'(m_br)) begin
         n_err++;
         $display("FAIL clr_discarded: block/we %b br_cnt %0d expected 00 br_cnt %0d",
                  {pred_block, tbl_we}, br_cnt, m_br);
      end
      adv();
   endtask

   task automatic test_rst_mid();
      set_idle();
      clr_req = 1'b1;
      @(negedge clk);
      model_eval();
      adv();
      idle_cycles(5);
      set_idle();
      @(negedge clk);
      model_eval();
      n_checks++;
      if (tbl_waddr !== 3'd5) begin
         n_err++;
         $display("FAIL rst_mid_pre: addr %0d expected 5", tbl_waddr);
      end
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({pred_block, tbl_we, tbl_wvalid, flush_req} !== 4'b1100 || tbl_waddr !== 3'd0 ||
          br_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL rst_mid_async: flags %b addr %0d cnt %0d/%0d expected 1100 0 0/0",
                  {pred_block, tbl_we, tbl_wvalid, flush_req}, tbl_waddr, br_cnt, miss_cnt);
      end
      adv();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         model_eval();
         n_checks++;
         if (tbl_waddr !== 3'(i) || pred_block !== 1'b1) begin
            n_err++;
            $display("FAIL rst_restart_%0d: addr %0d block %b expected %0d 1", i, tbl_waddr, pred_block, i);
         end
         adv();
      end
      idle_cycles(6);
   endtask

   task automatic test_saturate();
      logic [31:0] pc;
      for (int i = 0; i < 20; i++) begin
         pc = $urandom & 32'h0000_FFFC;
         set_in(1'b1, BR_OP, pc, pc + 32'd64, 1'b1, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         model_eval();
         n_checks++;
         if (br_cnt !== 4'(m_br) || miss_cnt !== 4'(m_miss)) begin
            n_err++;
            $display("FAIL sat_%0d: cnt %0d/%0d expected %0d/%0d", i, br_cnt, miss_cnt, m_br, m_miss);
         end
         adv();
      end
      set_idle();
      @(negedge clk);
      model_eval();
      n_checks++;
      if (br_cnt !== 4'hF || miss_cnt !== 4'hF) begin
         n_err++;
         $display("FAIL sat_final: cnt %0d/%0d expected 15/15", br_cnt, miss_cnt);
      end
      adv();
   endtask

   task automatic test_random();
      logic [31:0] pc, tgt;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            set_idle();
            model_reset();
         end else begin
            rst = 1'b0;
            pc  = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_00FC) : $urandom;
            tgt = $urandom;
            set_in(1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0) ? BR_OP : 7'($urandom),
                   pc, tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? tgt : $urandom,
                   1'($urandom_range(0, 29) == 0));
         end
         @(negedge clk);
         model_eval();
         n_checks++;
         if (flush_req !== e_flush || PC_redirect !== e_redir) begin
            n_err++;
            $display("FAIL rnd_flush_%0d: flush %b redirect %h expected %b %h", i, flush_req, PC_redirect, e_flush, e_redir);
         end
         n_checks++;
         if (stall_EX !== e_stall || pred_block !== e_pblock) begin
            n_err++;
            $display("FAIL rnd_ctrl_%0d: stall %b block %b expected %b %b", i, stall_EX, pred_block, e_stall, e_pblock);
         end
         n_checks++;
         if ({tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid} !== e_port) begin
            n_err++;
            $display("FAIL rnd_port_%0d: got %h expected %h", i,
                     {tbl_we, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken, tbl_wvalid}, e_port);
         end
         n_checks++;
         if (br_cnt !== 4'(m_br) || miss_cnt !== 4'(m_miss)) begin
            n_err++;
            $display("FAIL rnd_cnt_%0d: got %0d/%0d expected %0d/%0d", i, br_cnt, miss_cnt, m_br, m_miss);
         end
         adv();
      end
      rst = 1'b0;
   endtask

   initial begin
      set_idle();
      test_reset();
      test_sweep();
      test_mispredict();
      test_not_taken();
      test_back_to_back();
      test_clr_discard();
      test_rst_mid();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
